// File: rtl/nume_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : nume_deserializer
// Purpose  : Capture stage for the serial out_nume stream. Collects bits
//            strobed by bit_valid into a WORD_W-bit word (MSB first) after a
//            start strobe, pulses word_valid for each completed word, flags a
//            match against MATCH_VAL and counts completed frames.
// Revision : 1.0  initial release
// ============================================================================
module nume_deserializer #(
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] MATCH_VAL = 8'h4E,
    parameter int                CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              start,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              match,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy,
    output logic              abort
);

    // Bit counter only has to reach WORD_W-1 before the word completes.
    localparam int                 c_BCNT_W   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [c_BCNT_W-1:0] c_LAST_BIT = c_BCNT_W'(WORD_W - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE = c_BCNT_W'(1);
    localparam logic [CNT_W-1:0]    c_FCNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state;

    logic [WORD_W-1:0]   r_shreg;
    logic [WORD_W-1:0]   w_shreg;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [c_BCNT_W-1:0] w_bit_cnt;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word;
    logic                r_match;
    logic                w_match;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [CNT_W-1:0]    w_frame_cnt;
    logic                r_abort;
    logic                w_abort;
    logic                r_word_valid;
    logic                r_busy;

    // Shift register contents after taking bit_in, and a fresh register
    // holding bit_in as the first bit of a new frame.
    logic [WORD_W-1:0]   w_shifted;
    logic [WORD_W-1:0]   w_first;

    assign w_shifted = {r_shreg[WORD_W-2:0], bit_in};
    assign w_first   = {{(WORD_W-1){1'b0}}, bit_in};

    // State register; reset returns the FSM to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state and datapath decisions. start wins in every state: it opens a
    // new frame (discarding any partial word) and may carry that frame's bit 0.
    always_comb begin
        w_state     = r_state;
        w_shreg     = r_shreg;
        w_bit_cnt   = r_bit_cnt;
        w_word      = r_word;
        w_match     = r_match;
        w_frame_cnt = r_frame_cnt;
        w_abort     = 1'b0;

        if (start) begin
            w_state   = ST_SHIFT;
            w_shreg   = bit_valid ? w_first : '0;
            w_bit_cnt = bit_valid ? c_BCNT_ONE : '0;
            w_abort   = (r_state == ST_SHIFT);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_word      = w_shifted;
                            w_match     = (w_shifted == MATCH_VAL);
                            w_frame_cnt = r_frame_cnt + c_FCNT_ONE;
                            w_shreg     = '0;
                            w_bit_cnt   = '0;
                            w_state     = ST_DONE;
                        end else begin
                            w_shreg   = w_shifted;
                            w_bit_cnt = r_bit_cnt + c_BCNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers; word_valid/busy track the state being
    // entered so they line up exactly with DONE/SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_word       <= '0;
            r_match      <= 1'b0;
            r_frame_cnt  <= '0;
            r_abort      <= 1'b0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_shreg      <= w_shreg;
            r_bit_cnt    <= w_bit_cnt;
            r_word       <= w_word;
            r_match      <= w_match;
            r_frame_cnt  <= w_frame_cnt;
            r_abort      <= w_abort;
            r_word_valid <= (w_state == ST_DONE);
            r_busy       <= (w_state == ST_SHIFT);
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign match      = r_match;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = r_busy;
    assign abort      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_nume_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nume_deserializer
// Purpose  : Self-checking bench for nume_deserializer. A frame-level model
//            (bit queue, word/count bookkeeping) predicts every output each
//            cycle; scenario tasks add explicit checks on key values.
// Revision : 1.0  initial release
// ============================================================================
module tb_nume_deserializer;

    localparam int         WORD_W    = 8;
    localparam int         CNT_W     = 4;
    localparam logic [7:0] MATCH_VAL = 8'h4E;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              bit_in    = 1'b0;
    logic              bit_valid = 1'b0;
    logic              start     = 1'b0;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              match;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;
    logic              abort;

    int n_cmp = 0;
    int n_err = 0;

    nume_deserializer #(
        .WORD_W    (WORD_W),
        .MATCH_VAL (MATCH_VAL),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .word_out   (word_out),
        .word_valid (word_valid),
        .match      (match),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    // m_mode: 0 = waiting for start, 1 = collecting bits, 2 = word just completed
    int                m_mode;
    bit                m_bits[$];
    logic [WORD_W-1:0] m_word;
    logic              m_match;
    logic              m_wv;
    logic              m_abort;
    int                m_cnt;

    task automatic model_reset();
        m_mode  = 0;
        m_bits.delete();
        m_word  = '0;
        m_match = 1'b0;
        m_wv    = 1'b0;
        m_abort = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic s, input logic bv, input logic bi);
        logic [WORD_W-1:0] w;
        m_wv    = 1'b0;
        m_abort = 1'b0;
        if (s) begin
            if (m_mode == 1) m_abort = 1'b1;
            m_bits.delete();
            if (bv) m_bits.push_back(bi);
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bv) begin
                m_bits.push_back(bi);
                if (m_bits.size() == WORD_W) begin
                    w = '0;
                    foreach (m_bits[i]) w = {w[WORD_W-2:0], m_bits[i]};
                    m_word  = w;
                    m_match = (w == MATCH_VAL);
                    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                    m_wv    = 1'b1;
                    m_bits.delete();
                    m_mode  = 2;
                end
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {word_out, word_valid, match, frame_cnt, busy, abort};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_word, m_wv, m_match, CNT_W'(m_cnt), (m_mode == 1), m_abort};
    endfunction

    // One clock cycle of stimulus; outputs are then sampled 1 time unit later.
    task automatic step(input logic s, input logic bv, input logic bi);
        start     = s;
        bit_valid = bv;
        bit_in    = bi;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(s, bv, bi);
        #1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", dut_vec(), 16'h0000);
        end
        step(0, 0, 0);
        #2 rst_n = 1'b1;
        step(0, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [7:0] v = 8'hA5;
        step(1, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            if ($urandom_range(0, 1) == 1) begin
                step(0, 0, 1'($urandom));
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL basic_gap: got %h want %h", dut_vec(), exp_vec());
                end
            end
            step(0, 1, v[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL basic_bit: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (!(word_valid === 1'b1 && word_out === 8'hA5 && match === 1'b0 && frame_cnt === 4'd1)) begin
            n_err++;
            $display("FAIL basic_word: got wv=%b word=%h match=%b cnt=%0d want wv=1 word=a5 match=0 cnt=1",
                     word_valid, word_out, match, frame_cnt);
        end
        step(0, 0, 0);
        n_cmp++;
        if (word_valid !== 1'b0 || word_out !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_pulse: got wv=%b word=%h want wv=0 word=a5", word_valid, word_out);
        end
    endtask

    task automatic test_match();
        logic [7:0] v = MATCH_VAL;
        step(1, 1, v[7]);
        for (int i = 6; i >= 0; i--) begin
            step(0, 1, v[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL match_bit: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (!(word_valid === 1'b1 && match === 1'b1 && word_out === 8'h4E)) begin
            n_err++;
            $display("FAIL match_flag: got wv=%b match=%b word=%h want 1 1 4e", word_valid, match, word_out);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0);
            n_cmp++;
            if (match !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL match_hold: got %h want %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] v = MATCH_VAL;
        int         n_abort = 0;
        logic [3:0] cnt0;
        cnt0 = frame_cnt;
        step(1, 1, 1'($urandom));
        step(0, 1, 1'($urandom));
        step(0, 1, 1'($urandom));
        step(1, 0, 0);
        n_cmp++;
        if (abort !== 1'b1 || word_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_pulse: got %h want %h", dut_vec(), exp_vec());
        end
        if (abort === 1'b1) n_abort++;
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, v[i]);
            if (abort === 1'b1) n_abort++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL abort_frame: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (n_abort != 1 || word_out !== 8'h4E || frame_cnt !== cnt0 + 4'd1) begin
            n_err++;
            $display("FAIL abort_result: got aborts=%0d word=%h cnt=%0d want aborts=1 word=4e cnt=%0d",
                     n_abort, word_out, frame_cnt, cnt0 + 4'd1);
        end
        step(0, 0, 0);
    endtask

    task automatic test_idle_bits();
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 1'($urandom));
            n_cmp++;
            if (busy !== 1'b0 || word_valid !== 1'b0 || word_out !== 8'h4E || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL idle_bits: got %h want %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 17; f++) begin
            d = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                step(i == 7, 1, d[i]);
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL b2b_cycle f%0d: got %h want %h", f, dut_vec(), exp_vec());
                end
            end
            n_cmp++;
            if (word_valid !== 1'b1 || word_out !== d) begin
                n_err++;
                $display("FAIL b2b_word f%0d: got wv=%b word=%h want wv=1 word=%h", f, word_valid, word_out, d);
            end
        end
        step(0, 0, 0);
        n_cmp++;
        if (frame_cnt !== 4'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_wrap: got cnt=%0d busy=%b want cnt=1 busy=0", frame_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== 16'h0000) begin
            n_err++;
            $display("FAIL rstmid_async: got %h want %h", dut_vec(), 16'h0000);
        end
        step(0, 1, 1);
        step(0, 1, 1);
        n_cmp++;
        if (word_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL rstmid_hold: got %h want %h", dut_vec(), exp_vec());
        end
        rst_n = 1'b1;
        d = 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
            step(i == 7, 1, d[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rstmid_frame: got %h want %h", dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (word_valid !== 1'b1 || word_out !== d || frame_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL rstmid_word: got wv=%b word=%h cnt=%0d want wv=1 word=%h cnt=1",
                     word_valid, word_out, frame_cnt, d);
        end
        step(0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_match();
        test_abort();
        test_idle_bits();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
